// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        ON   = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // NOTE: a constant table synthesizes to plain decode logic; no storage and no reset is involved.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 4-digit seven-segment scanner with per-slot anode dead time.
// Optional leading-zero blanking is built when SEG_LZ_BLANK_EN is defined.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int DWELL_CYC = 100000,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       disp_en,
    input  logic [3:0] mux_nibble,
    output logic [1:0] mux_sel,
    output logic [3:0] anode_n,
    output logic [6:0] seg_n,
    output logic       frame_done
);

    localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    scan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0] w_glyph;
    logic [6:0] w_seg_next;
    logic [3:0] w_anode_on;
    logic       w_gap_end;
    logic       w_slot_end;

    hex_to_seg u_hex_to_seg (
        .i_nibble (mux_nibble),
        .o_seg    (w_glyph)
    );

    assign w_anode_on = ~(4'b0001 << mux_sel);
    assign w_gap_end  = (r_state == GAP) && (r_cnt == GAP_LAST);
    assign w_slot_end = (r_state == ON)  && (r_cnt == DWELL_LAST);

`ifdef SEG_LZ_BLANK_EN
    logic r_all_higher_zero;
    logic w_enter_top_digit;
    logic w_blank;

    // A frame starts either from IDLE or when digit 0 wraps back to digit 3.
    assign w_enter_top_digit = disp_en &&
                               ((r_state == IDLE) || (w_slot_end && (mux_sel == 2'd0)));
    assign w_blank    = r_all_higher_zero && (mux_sel != 2'd0) && (mux_nibble == 4'd0);
    assign w_seg_next = w_blank ? SEG_BLANK : w_glyph;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_all_higher_zero <= 1'b1;
        end else if (w_enter_top_digit) begin
            r_all_higher_zero <= 1'b1;
        end else if (w_gap_end && (mux_nibble != 4'd0)) begin
            r_all_higher_zero <= 1'b0;
        end
    end
`else
    assign w_seg_next = w_glyph;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            mux_sel    <= 2'd3;
            anode_n    <= 4'hF;
            seg_n      <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!disp_en) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                mux_sel <= 2'd3;
                anode_n <= 4'hF;
                seg_n   <= SEG_BLANK;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                        mux_sel <= 2'd3;
                        anode_n <= 4'hF;
                        seg_n   <= SEG_BLANK;
                    end
                    GAP: begin
                        // The external mux settles within the cycle, so the last GAP sample is the one shown.
                        seg_n <= w_seg_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_gap_end) begin
                            r_state <= ON;
                            anode_n <= w_anode_on;
                        end
                    end
                    ON: begin
                        if (w_slot_end) begin
                            r_state    <= GAP;
                            r_cnt      <= '0;
                            mux_sel    <= mux_sel - 2'd1;
                            anode_n    <= 4'hF;
                            frame_done <= (mux_sel == 2'd0);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: stimulus queues expected ON slots, a monitor pops and compares.
// Expectations for the blanking frames follow SEG_LZ_BLANK_EN.
module tb_seg_scan_controller;

    localparam int DWELL = 8;
    localparam int GAPC  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        disp_en = 1'b0;
    logic [15:0] mux_val = 16'h1A03;
    logic [3:0]  mux_nibble;
    logic [1:0]  mux_sel;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        frame_done;

    assign mux_nibble = mux_val[{mux_sel, 2'b00} +: 4];

    always #5 clk = ~clk;

    seg_scan_controller #(
        .DWELL_CYC (DWELL),
        .GAP_CYC   (GAPC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp_en    (disp_en),
        .mux_nibble (mux_nibble),
        .mux_sel    (mux_sel),
        .anode_n    (anode_n),
        .seg_n      (seg_n),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] an;
        logic [6:0] seg;
        int         len;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int fd_count = 0;
    int fd_last = 0;
    bit fd_prev_valid = 1'b0;
    int fd_snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic push_slot(input logic [1:0] sel, input logic [3:0] an,
                             input logic [6:0] seg, input int len);
        exp_t e;
        e.sel = sel;
        e.an  = an;
        e.seg = seg;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        push_slot(2'd3, 4'h7, s3, DWELL - GAPC);
        push_slot(2'd2, 4'hB, s2, DWELL - GAPC);
        push_slot(2'd1, 4'hD, s1, DWELL - GAPC);
        push_slot(2'd0, 4'hE, s0, DWELL - GAPC);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mux_sel"},    32'(mux_sel),    32'd3);
        check({tag, "_anode_n"},    32'(anode_n),    32'hF);
        check({tag, "_seg_n"},      32'(seg_n),      32'h7F);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        if (frame_done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: frame_done not seen within %0d cycles", tag, n);
        end
    endtask

    task automatic wait_anode(input logic [3:0] v, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (anode_n !== v && n < 200);
        if (anode_n !== v) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: anode_n=0x%0h, want 0x%0h", tag, anode_n, v);
        end
    endtask

    // Monitor: one scoreboard entry per ON slot, plus frame period tracking.
    bit         in_on = 1'b0;
    bit         have_cur = 1'b0;
    int         on_len = 0;
    int         seg_chg = 0;
    logic [6:0] on_seg;
    exp_t       cur;

    always @(negedge clk) begin
        cyc++;
        if (frame_done === 1'b1) begin
            fd_count++;
            if (fd_prev_valid) check("frame_period", 32'(cyc - fd_last), 32'(4 * DWELL));
            fd_last = cyc;
            fd_prev_valid = 1'b1;
        end
        if (anode_n !== 4'hF) begin
            if (!in_on) begin
                in_on   = 1'b1;
                on_len  = 1;
                seg_chg = 0;
                on_seg  = seg_n;
                if (sb.size() == 0) begin
                    have_cur = 1'b0;
                    n_cmp++;
                    n_fail++;
                    $display("FAIL slot_unexpected at %0t: sel=%0d anode_n=0x%0h seg_n=0x%0h, want no slot",
                             $time, mux_sel, anode_n, seg_n);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    check("slot_sel_anode_seg", 32'({mux_sel, anode_n, seg_n}),
                          32'({cur.sel, cur.an, cur.seg}));
                end
            end else begin
                on_len++;
                if (seg_n !== on_seg) seg_chg++;
            end
        end else if (in_on) begin
            in_on = 1'b0;
            if (have_cur && cur.len != 0) begin
                check("on_len", 32'(on_len), 32'(cur.len));
                check("seg_hold_changes", 32'(seg_chg), 32'd0);
            end
        end
    end

    initial begin
        #3 reset_n = 1'b0;
        #1 check_reset_vals("reset_async_t0");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_blank", 32'({mux_sel, anode_n, seg_n}), 32'({2'd3, 4'hF, 7'h7F}));

        // Frames 1-3 show 1A03; digit 2 is changed mid-ON in frame 3 and shows C in frame 4.
        push_frame(7'h79, 7'h08, 7'h40, 7'h30);
        push_frame(7'h79, 7'h08, 7'h40, 7'h30);
        push_frame(7'h79, 7'h08, 7'h40, 7'h30);
        push_slot(2'd3, 4'h7, 7'h79, DWELL - GAPC);
        push_slot(2'd2, 4'hB, 7'h46, DWELL - GAPC);
        push_slot(2'd1, 4'hD, 7'h40, 0);
        disp_en = 1'b1;
        wait_fd("frame1");
        wait_fd("frame2");
        wait_anode(4'hB, "f3_digit2");
        repeat (2) @(negedge clk);
        mux_val = 16'h1C03;
        wait_fd("frame3");

        // Disable during digit 1 ON of frame 4.
        wait_anode(4'hD, "f4_digit1");
        disp_en = 1'b0;
        fd_prev_valid = 1'b0;
        fd_snap = fd_count;
        @(negedge clk);
        check("dis_anode_n",    32'(anode_n),    32'hF);
        check("dis_seg_n",      32'(seg_n),      32'h7F);
        check("dis_mux_sel",    32'(mux_sel),    32'd3);
        check("dis_frame_done", 32'(frame_done), 32'd0);
        repeat (20) @(negedge clk);
        check("no_partial_frame_done", 32'(fd_count), 32'(fd_snap));

        // Re-enable: full GAP on digit 3 first.
        mux_val = 16'h1A03;
        push_frame(7'h79, 7'h08, 7'h40, 7'h30);
        disp_en = 1'b1;
        @(negedge clk);
        check("reen_gap0", 32'({mux_sel, anode_n}), 32'({2'd3, 4'hF}));
        @(negedge clk);
        check("reen_gap1", 32'({mux_sel, anode_n}), 32'({2'd3, 4'hF}));
        @(negedge clk);
        check("reen_on", 32'(anode_n), 32'h7);
        wait_fd("reen_frame");

        // Async reset mid-GAP (frame_done is high right now).
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset_mid_gap");
        fd_prev_valid = 1'b0;
        push_slot(2'd3, 4'h7, 7'h79, DWELL - GAPC);
        push_slot(2'd2, 4'hB, 7'h08, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Async reset mid-ON of digit 2.
        wait_anode(4'hB, "rst_digit2");
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset_mid_on");
        disp_en = 1'b0;
        fd_prev_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Leading-zero frames: 0005, 0000, 0105.
`ifdef SEG_LZ_BLANK_EN
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h12);
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40);
        push_frame(7'h7F, 7'h79, 7'h40, 7'h12);
`else
        push_frame(7'h40, 7'h40, 7'h40, 7'h12);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40);
        push_frame(7'h40, 7'h79, 7'h40, 7'h12);
`endif
        mux_val = 16'h0005;
        repeat (2) @(negedge clk);
        disp_en = 1'b1;
        wait_fd("lz_0005");
        mux_val = 16'h0000;
        wait_fd("lz_0000");
        mux_val = 16'h0105;
        wait_fd("lz_0105");
        disp_en = 1'b0;
        repeat (10) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
